multicycle_cu: RTL and testbench

Parametrised multi-cycle control unit for the simple CPU datapath, with a configurable register count, a valid/ready instruction handshake, a completion pulse and an optional hardwired-zero register. It drives the registered ALU (operand/opcode), the registered data memory (write enable, store data), and the result2/operand_b steering selects. It writes back ALU or memory results into its internal register file. One instruction is in flight at a time.

---
 rtl/multicycle_cu.sv | 163 ++++++++++++++++
 tb/tb_multicycle_cu.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_cu.sv
// multicycle_cu: multi-cycle control unit for the simple CPU datapath.
// Optional debug read port: define CU_DEBUG_PORT_EN.
//
// Ports:
//   clk, rst             clock, async active-high reset
//   instr, instr_valid   instruction in, {class,rd,rs1,rs2,offset,opcode}
//   instr_ready          high in IDLE while rst is low
//   result2              write-back data (ALU or memory)
//   operand1/2, offset   ALU operands / store data / immediate
//   opcode               ALU opcode (0 add, 1 sub)
//   sel1, sel3           result2 source / ALU operand B source
//   w_r                  data memory write enable
//   done                 high for the WRITE_BACK cycle
//   dbg_addr, dbg_data   register read port (CU_DEBUG_PORT_EN only)
module multicycle_cu #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5,
  parameter int NUM_REGS   = 4,
  parameter int R0_ZERO    = 0,
  localparam int REG_BITS    = $clog2(NUM_REGS),
  localparam int INSTR_WIDTH = 2 + 3*REG_BITS + DATA_WIDTH + 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic [DATA_WIDTH-1:0]  result2,
  output logic [DATA_WIDTH-1:0]  operand1,
  output logic [DATA_WIDTH-1:0]  operand2,
  output logic [DATA_WIDTH-1:0]  offset,
  output logic [3:0]             opcode,
  output logic                   sel1,
  output logic                   sel3,
  output logic                   w_r,
  output logic                   done
`ifdef CU_DEBUG_PORT_EN
  ,
  input  logic [REG_BITS-1:0]    dbg_addr,
  output logic [DATA_WIDTH-1:0]  dbg_data
`endif
);

  if (ADDR_BITS < 1 || ADDR_BITS > DATA_WIDTH) begin : g_bad_addr
    $error("multicycle_cu: ADDR_BITS must be 1..DATA_WIDTH");
  end
  if (NUM_REGS < 2 || (1 << REG_BITS) != NUM_REGS) begin : g_bad_regs
    $error("multicycle_cu: NUM_REGS must be a power of two >= 2");
  end

  localparam int OFF_LSB = 4;
  localparam int RS2_LSB = OFF_LSB + DATA_WIDTH;
  localparam int RS1_LSB = RS2_LSB + REG_BITS;
  localparam int RD_LSB  = RS1_LSB + REG_BITS;
  localparam int CLS_LSB = RD_LSB + REG_BITS;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    C_NOP   = 2'b00,
    C_STD   = 2'b01,
    C_LOAD  = 2'b10,
    C_STORE = 2'b11
  } cls_t;

  state_t state, state_n;
  cls_t   cls_q;
  logic [REG_BITS-1:0]   rd_q;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic [1:0]            in_cls;
  logic [REG_BITS-1:0]   in_rd, in_rs1, in_rs2;
  logic [DATA_WIDTH-1:0] in_off;
  logic [3:0]            in_op;
  logic                  in_mem;
  logic                  accept;
  logic                  wb_en;

  assign in_cls = instr[CLS_LSB +: 2];
  assign in_rd  = instr[RD_LSB +: REG_BITS];
  assign in_rs1 = instr[RS1_LSB +: REG_BITS];
  assign in_rs2 = instr[RS2_LSB +: REG_BITS];
  assign in_off = instr[OFF_LSB +: DATA_WIDTH];
  assign in_op  = instr[3:0];
  // load and store both have class bit 1 set
  assign in_mem = in_cls[1];

  assign instr_ready = (state == S_IDLE) && !rst;
  assign accept      = instr_valid && instr_ready;
  assign done        = (state == S_WB);

  function automatic logic [DATA_WIDTH-1:0] rd_reg(
    input logic [REG_BITS-1:0] a
  );
    if (R0_ZERO != 0 && a == '0) return '0;
    return regs[a];
  endfunction

  assign wb_en = (cls_q == C_STD || cls_q == C_LOAD) &&
                 !(R0_ZERO != 0 && rd_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = S_IDLE;
    unique case (state)
      S_IDLE:    state_n = accept ? S_DECODE : S_IDLE;
      S_DECODE:  state_n = (cls_q == C_NOP) ? S_WB : S_EXECUTE;
      S_EXECUTE: state_n = (cls_q == C_STD) ? S_WB : S_MEM;
      S_MEM:     state_n = S_WB;
      S_WB:      state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      operand1 <= '0;
      operand2 <= '0;
      offset   <= '0;
      opcode   <= 4'hF;
      sel1     <= 1'b0;
      sel3     <= 1'b0;
      w_r      <= 1'b0;
      cls_q    <= C_NOP;
      rd_q     <= '0;
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= DATA_WIDTH'(i);
    end else begin
      if (accept) begin
        operand1 <= rd_reg(in_rs1);
        operand2 <= rd_reg(in_mem ? in_rd : in_rs2);
        offset   <= in_off;
        opcode   <= in_op;
        sel1     <= !in_mem;
        sel3     <= in_mem;
        w_r      <= 1'b0;
        cls_q    <= cls_t'(in_cls);
        rd_q     <= in_rd;
      end else if (state == S_EXECUTE && cls_q == C_STORE) begin
        w_r <= 1'b1;
      end else if (state == S_MEM) begin
        w_r <= 1'b0;
      end
      if (state == S_WB && wb_en)
        regs[rd_q] <= result2;
    end
  end

`ifdef CU_DEBUG_PORT_EN
  assign dbg_data = rd_reg(dbg_addr);
`endif

endmodule

// File: tb/tb_multicycle_cu.sv
// tb_multicycle_cu: directed bench for multicycle_cu with a
// registered ALU and data memory model; expectations via queues.
module tb_multicycle_cu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [7:0]  result2, operand1, operand2, offset;
  logic [3:0]  opcode;
  logic        sel1, sel3, w_r, done;

  logic [19:0] z_instr = '0;
  logic        z_valid = 1'b0;
  logic        z_ready;
  logic [7:0]  z_result2, z_op1, z_op2, z_off;
  logic [3:0]  z_opcode;
  logic        z_sel1, z_sel3, z_w_r, z_done;

`ifdef CU_DEBUG_PORT_EN
  logic [1:0] dbg_addr = '0, z_dbg_addr = '0;
  logic [7:0] dbg_data, z_dbg_data;
`endif

  always #5 clk = ~clk;

  multicycle_cu #(.DATA_WIDTH(8), .ADDR_BITS(5), .NUM_REGS(4),
                  .R0_ZERO(0)) dut (
    .clk(clk), .rst(rst), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .result2(result2), .operand1(operand1), .operand2(operand2),
    .offset(offset), .opcode(opcode), .sel1(sel1), .sel3(sel3),
    .w_r(w_r), .done(done)
`ifdef CU_DEBUG_PORT_EN
    , .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`endif
  );

  multicycle_cu #(.DATA_WIDTH(8), .ADDR_BITS(5), .NUM_REGS(4),
                  .R0_ZERO(1)) dut_z (
    .clk(clk), .rst(rst), .instr(z_instr),
    .instr_valid(z_valid), .instr_ready(z_ready),
    .result2(z_result2), .operand1(z_op1), .operand2(z_op2),
    .offset(z_off), .opcode(z_opcode), .sel1(z_sel1), .sel3(z_sel3),
    .w_r(z_w_r), .done(z_done)
`ifdef CU_DEBUG_PORT_EN
    , .dbg_addr(z_dbg_addr), .dbg_data(z_dbg_data)
`endif
  );

  // registered ALU and data memory models
  logic [7:0] alu_q, mem_q, z_alu_q;
  logic [7:0] mem [32];
  int         wr_cnt = 0, done_cnt = 0;
  logic [4:0] wr_addr = '0;

  always @(posedge clk) begin
    alu_q <= sel3 ? operand1 + offset :
             (opcode == 4'd1 ? operand1 - operand2 : operand1 + operand2);
    z_alu_q <= z_sel3 ? z_op1 + z_off :
               (z_opcode == 4'd1 ? z_op1 - z_op2 : z_op1 + z_op2);
    mem_q <= mem[alu_q[4:0]];
    if (w_r) begin
      mem[alu_q[4:0]] <= operand2;
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= alu_q[4:0];
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  assign result2   = sel1 ? alu_q : mem_q;
  assign z_result2 = z_sel1 ? z_alu_q : 8'h00;

  int vectors = 0, miscompares = 0;
  int lat_q[$];
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] mk(input logic [1:0] c,
    input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2,
    input logic [7:0] off, input logic [3:0] op);
    return {c, rd, rs1, rs2, off, op};
  endfunction

  function automatic logic rdy(input bit z);
    return z ? z_ready : instr_ready;
  endfunction

  function automatic logic dn(input bit z);
    return z ? z_done : done;
  endfunction

  task automatic issue(input bit z, input logic [19:0] ins,
                       input int exp_lat, input string tag);
    int n, k;
    lat_q.push_back(exp_lat);
    if (z) begin z_instr = ins; z_valid = 1'b1; end
    else begin instr = ins; instr_valid = 1'b1; end
    n = 0;
    while (!rdy(z) && n < 20) begin @(posedge clk); #1; n++; end
    check({tag, "_accept"}, 32'(rdy(z)), 1);
    @(posedge clk); #1;
    if (z) z_valid = 1'b0; else instr_valid = 1'b0;
    k = 0;
    while (!dn(z) && k < 20) begin @(posedge clk); #1; k++; end
    check({tag, "_done_lat"}, k, lat_q.pop_front());
    @(posedge clk); #1;
    check({tag, "_done_end"}, 32'(dn(z)), 0);
  endtask

  // NOP reads rs1/rs2 onto operand1/operand2
  task automatic rd_chk(input bit z, input logic [1:0] a,
    input logic [1:0] b, input logic [7:0] ea, input logic [7:0] eb,
    input string tag);
    exp_q.push_back(ea);
    exp_q.push_back(eb);
    issue(z, mk(2'b00, 2'd0, a, b, 8'hA5, 4'h3), 1, tag);
    check({tag, "_op1"}, z ? z_op1 : operand1, exp_q.pop_front());
    check({tag, "_op2"}, z ? z_op2 : operand2, exp_q.pop_front());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, d0, w0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", instr_ready, 0);
    check("rst_opcode", opcode, 4'hF);
    check("rst_outs", {operand1, operand2, offset, sel1, sel3, w_r, done},
          0);
    rst = 1'b0;
    #1;
    check("rel_ready", instr_ready, 1);
`ifdef CU_DEBUG_PORT_EN
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      check("dbg_rst", dbg_data, i);
    end
`endif
    @(posedge clk); #1;

    rd_chk(0, 0, 1, 8'h00, 8'h01, "rst_r01");
    rd_chk(0, 2, 3, 8'h02, 8'h03, "rst_r23");
    check("nop_off_op", {offset, opcode}, {8'hA5, 4'h3});
    check("nop_sel", {sel1, sel3}, 2'b10);

    issue(0, mk(2'b01, 2'd3, 2'd1, 2'd2, 8'h00, 4'd0), 2, "add");
    issue(0, mk(2'b01, 2'd0, 2'd1, 2'd2, 8'h00, 4'd1), 2, "sub");
    rd_chk(0, 0, 3, 8'hFF, 8'h03, "after_sub");
    issue(0, mk(2'b01, 2'd0, 2'd0, 2'd3, 8'h00, 4'd0), 2, "wrap");
    rd_chk(0, 0, 1, 8'h02, 8'h01, "after_wrap");

    w0 = wr_cnt;
    issue(0, mk(2'b11, 2'd3, 2'd1, 2'd0, 8'h04, 4'd0), 3, "store");
    check("st_wr_cycles", wr_cnt - w0, 1);
    check("st_addr", wr_addr, 5);
    check("st_mem5", mem[5], 8'h03);
    check("st_sel", {sel1, sel3, w_r}, 3'b010);

    issue(0, mk(2'b10, 2'd2, 2'd1, 2'd0, 8'h04, 4'd0), 3, "load");
    rd_chk(0, 2, 3, 8'h03, 8'h03, "after_load");

    // back-to-back std with instr_valid held high
    d0 = done_cnt;
    instr = mk(2'b01, 2'd1, 2'd3, 2'd2, 8'h00, 4'd0);
    instr_valid = 1'b1;
    check("hs_ready_idle", instr_ready, 1);
    @(posedge clk); #1;
    instr = mk(2'b01, 2'd2, 2'd3, 2'd1, 8'h00, 4'd1);
    check("hs_ready_e0", instr_ready, 0);
    @(posedge clk); #1;
    check("hs_ready_e1", instr_ready, 0);
    @(posedge clk); #1;
    check("hs_ready_e2", {instr_ready, done}, 2'b01);
    @(posedge clk); #1;
    check("hs_ready_e3", instr_ready, 1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("hs_accept_e4", instr_ready, 0);
    k = 0;
    while (!done && k < 20) begin @(posedge clk); #1; k++; end
    check("hs_done_lat2", k, 2);
    @(posedge clk); #1;
    check("hs_done_count", done_cnt - d0, 2);
    rd_chk(0, 1, 2, 8'h06, 8'hFD, "after_hs");

    // reset during MEM_ACCESS of a store to mem[5]
    w0 = wr_cnt;
    instr = mk(2'b11, 2'd1, 2'd0, 2'd0, 8'h03, 4'd0);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    k = 0;
    while (!w_r && k < 10) begin @(posedge clk); #1; k++; end
    check("mid_wr_seen", w_r, 1);
    rst = 1'b1;
    #1;
    check("mid_wr_drop", {w_r, done, instr_ready}, 3'b000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_no_write", wr_cnt - w0, 0);
    check("mid_mem5", mem[5], 8'h03);
    @(posedge clk); #1;
    rd_chk(0, 0, 1, 8'h00, 8'h01, "mid_r01");
    rd_chk(0, 2, 3, 8'h02, 8'h03, "mid_r23");

    // hardwired-zero register instance
    issue(1, mk(2'b01, 2'd0, 2'd1, 2'd2, 8'h00, 4'd0), 2, "z_add");
`ifdef CU_DEBUG_PORT_EN
    z_dbg_addr = 2'd0;
    #1;
    check("z_dbg_r0", z_dbg_data, 0);
`endif
    rd_chk(1, 0, 3, 8'h00, 8'h03, "z_r0");
    issue(1, mk(2'b01, 2'd1, 2'd0, 2'd1, 8'h00, 4'd1), 2, "z_sub");
    rd_chk(1, 1, 0, 8'hFF, 8'h00, "z_r1");

    check("queues_empty", lat_q.size() + exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
